// File: rtl/eeprom_arbiter.sv
// eeprom_arbiter: round-robin arbiter sharing one EEPROM_WR engine between two requesters
module eeprom_arbiter #(
  parameter int ADDR_W  = 11,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 4000
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic [1:0]          req,
  input  logic [1:0]          we,
  input  logic [2*ADDR_W-1:0] addr,
  input  logic [2*DATA_W-1:0] wdata,
  output logic [1:0]          gnt,
  output logic [1:0]          done,
  output logic [1:0]          err,
  output logic [DATA_W-1:0]   rdata,
  output logic                busy,
  output logic                WR,
  output logic                RD,
  output logic [ADDR_W-1:0]   ADDR,
  inout  wire  [DATA_W-1:0]   DATA,
  input  logic                ACK
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  localparam logic [15:0] LAST = 16'(TIMEOUT - 1);
  state_t state, state_n;
  logic last, last_n, pick, wr_n, rd_n, busy_n;
  logic [15:0] cnt, cnt_n;
  logic [DATA_W-1:0] wd, wd_n, rdata_n;
  logic [ADDR_W-1:0] addr_n;
  logic [1:0] gnt_n, done_n, err_n;
  assign DATA = WR ? wd : 'z;
  always_comb begin
    pick = (req == 2'b11) ? ~last : req[1];
    state_n = state;
    last_n = last;
    cnt_n = cnt;
    wd_n = wd;
    rdata_n = rdata;
    addr_n = ADDR;
    wr_n = WR;
    rd_n = RD;
    gnt_n = gnt;
    busy_n = busy;
    done_n = '0;
    err_n = '0;
    case (state)
      IDLE: if (|req) begin
        state_n = BUSY;
        last_n = pick;
        cnt_n = '0;
        wd_n = pick ? wdata[2*DATA_W-1:DATA_W] : wdata[DATA_W-1:0];
        addr_n = pick ? addr[2*ADDR_W-1:ADDR_W] : addr[ADDR_W-1:0];
        wr_n = we[pick];
        rd_n = ~we[pick];
        gnt_n = pick ? 2'b10 : 2'b01;
        busy_n = 1'b1;
      end
      BUSY: begin
        cnt_n = cnt + 16'd1;
        if (ACK || cnt == LAST) begin
          state_n = DONE;
          wr_n = 1'b0;
          rd_n = 1'b0;
          done_n = gnt;
          err_n = ACK ? 2'b00 : gnt;
          rdata_n = (ACK && RD) ? DATA : rdata;
        end
      end
      default: begin
        state_n = IDLE;
        gnt_n = '0;
        busy_n = 1'b0;
      end
    endcase
  end
  // last starts at 1 so the first tie goes to requester 0
  always_ff @(posedge CLK)
    if (RESET) begin
      state <= IDLE;
      last <= 1'b1;
      cnt <= '0;
      wd <= '0;
      rdata <= '0;
      ADDR <= '0;
      WR <= 1'b0;
      RD <= 1'b0;
      gnt <= '0;
      busy <= 1'b0;
      done <= '0;
      err <= '0;
    end else begin
      state <= state_n;
      last <= last_n;
      cnt <= cnt_n;
      wd <= wd_n;
      rdata <= rdata_n;
      ADDR <= addr_n;
      WR <= wr_n;
      RD <= rd_n;
      gnt <= gnt_n;
      busy <= busy_n;
      done <= done_n;
      err <= err_n;
    end
endmodule

// File: tb/tb_eeprom_arbiter.sv
// tb_eeprom_arbiter: directed and randomized transactions checked against a round-robin model
module tb_eeprom_arbiter;
  localparam int AW = 11, DW = 8, TO = 16;
  logic CLK = 0, RESET = 1, ACK = 0;
  logic [1:0] req = 0, we = 0;
  logic [2*AW-1:0] addr = 0;
  logic [2*DW-1:0] wdata = 0;
  logic [1:0] gnt, done, err;
  logic [DW-1:0] rdata;
  logic busy, WR, RD;
  logic [AW-1:0] ADDR;
  wire [DW-1:0] DATA;
  logic [DW-1:0] drv = 0;
  logic drv_en = 0;
  int n_chk = 0, n_fail = 0;
  logic last_m = 1'b1;
  logic [DW-1:0] rdata_m = 0;
  assign DATA = drv_en ? drv : 'z;
  eeprom_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .CLK(CLK), .RESET(RESET), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .gnt(gnt), .done(done), .err(err), .rdata(rdata), .busy(busy),
    .WR(WR), .RD(RD), .ADDR(ADDR), .DATA(DATA), .ACK(ACK)
  );
  always #5 CLK = ~CLK;
  // One full transaction from IDLE; ack_at is the BUSY cycle (1-based) that sees ACK, 0 = never
  task automatic do_txn(input int ack_at, input logic [DW-1:0] rd_val, input bit mess);
    logic o, w, acked;
    logic [1:0] g;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    o = (req == 2'b11) ? ~last_m : req[1];
    last_m = o;
    w = we[o];
    g = o ? 2'b10 : 2'b01;
    a = o ? addr[2*AW-1:AW] : addr[AW-1:0];
    d = o ? wdata[2*DW-1:DW] : wdata[DW-1:0];
    acked = 0;
    @(posedge CLK); @(negedge CLK);
    n_chk++;
    if ({gnt, busy, WR, RD, ADDR} !== {g, 1'b1, w, ~w, a}) begin
      n_fail++;
      $display("FAIL grant: gnt=%b busy=%b WR=%b RD=%b ADDR=%h, want gnt=%b busy=1 WR=%b RD=%b ADDR=%h", gnt, busy, WR, RD, ADDR, g, w, ~w, a);
    end
    for (int k = 1; k <= TO; k++) begin
      n_chk++;
      if ({WR, RD, gnt, ADDR} !== {w, ~w, g, a} || (w && DATA !== d)) begin
        n_fail++;
        $display("FAIL busy_hold cycle %0d: WR=%b RD=%b gnt=%b ADDR=%h DATA=%h, want WR=%b RD=%b gnt=%b ADDR=%h DATA=%h", k, WR, RD, gnt, ADDR, DATA, w, ~w, g, a, d);
      end
      if (mess && k == 2) begin
        req = 0;
        we = 2'($urandom);
        addr = 22'($urandom);
        wdata = 16'($urandom);
      end
      if (k == ack_at) begin
        ACK = 1;
        acked = 1;
        drv = rd_val;
        drv_en = ~w;
      end
      @(posedge CLK); @(negedge CLK);
      ACK = 0;
      drv_en = 0;
      if (acked) break;
    end
    if (acked && !w) rdata_m = rd_val;
    n_chk++;
    if ({gnt, done, err, busy, WR, RD, rdata} !== {g, g, (acked ? 2'b00 : g), 1'b1, 2'b00, rdata_m}) begin
      n_fail++;
      $display("FAIL done_cycle: gnt=%b done=%b err=%b busy=%b WR=%b RD=%b rdata=%h, want gnt=%b done=%b err=%b busy=1 WR=0 RD=0 rdata=%h", gnt, done, err, busy, WR, RD, rdata, g, g, (acked ? 2'b00 : g), rdata_m);
    end
    @(posedge CLK); @(negedge CLK);
    n_chk++;
    if ({gnt, done, err, busy, WR, RD} !== 8'b0) begin
      n_fail++;
      $display("FAIL idle_after: gnt=%b done=%b err=%b busy=%b WR=%b RD=%b, want all 0", gnt, done, err, busy, WR, RD);
    end
  endtask
  task automatic test_reset;
    RESET = 1;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    n_chk++;
    if ({gnt, done, err, busy, WR, RD, ADDR, rdata} !== '0) begin
      n_fail++;
      $display("FAIL reset: gnt=%b done=%b err=%b busy=%b WR=%b RD=%b ADDR=%h rdata=%h, want all 0", gnt, done, err, busy, WR, RD, ADDR, rdata);
    end
    RESET = 0;
  endtask
  task automatic test_write;
    req = 2'b01; we = 2'b01; addr = {11'h0, 11'h155}; wdata = {8'h0, 8'hA5};
    do_txn(12, 8'h00, 0);
    req = 0;
  endtask
  task automatic test_read;
    req = 2'b10; we = 2'b00; addr = {11'h7FF, 11'h0}; wdata = 0;
    do_txn(5, 8'h3C, 0);
    n_chk++;
    if (rdata !== 8'h3C) begin
      n_fail++;
      $display("FAIL read_data: rdata=%h, want 3c", rdata);
    end
    req = 0;
  endtask
  task automatic test_back_to_back;
    req = 2'b11; we = 2'b10; addr = {11'h2AA, 11'h0F0}; wdata = {8'h5A, 8'hC3};
    repeat (4) do_txn(5, 8'h77, 0);
    req = 0;
  endtask
  task automatic test_timeout;
    req = 2'b01; we = 2'b01; addr = {11'h0, 11'h123}; wdata = {8'h0, 8'h99};
    do_txn(0, 8'h00, 0);
    do_txn(TO, 8'h00, 0);
    we = 2'b00;
    do_txn(0, 8'h11, 0);
    req = 0;
  endtask
  task automatic test_reset_mid;
    req = 2'b01; we = 2'b01; addr = {11'h0, 11'h321}; wdata = {8'h0, 8'h42};
    @(posedge CLK); @(negedge CLK);
    n_chk++;
    if (WR !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_mid_start: WR=%b, want 1", WR);
    end
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    RESET = 1;
    @(posedge CLK); @(negedge CLK);
    n_chk++;
    if ({gnt, done, err, busy, WR, RD, ADDR, rdata} !== '0) begin
      n_fail++;
      $display("FAIL reset_mid: gnt=%b done=%b err=%b busy=%b WR=%b RD=%b ADDR=%h rdata=%h, want all 0", gnt, done, err, busy, WR, RD, ADDR, rdata);
    end
    RESET = 0;
    last_m = 1'b1;
    rdata_m = 0;
    req = 2'b11;
    do_txn(4, 8'h00, 0);
    req = 0;
  endtask
  task automatic test_drop_and_spurious;
    req = 2'b01; we = 2'b00; addr = {11'h0, 11'h044}; wdata = 0;
    do_txn(7, 8'hD2, 1);
    req = 0;
    ACK = 1; drv = 8'hEE; drv_en = 1;
    @(posedge CLK); @(negedge CLK);
    ACK = 0; drv_en = 0;
    for (int i = 0; i < 2; i++) begin
      n_chk++;
      if ({gnt, done, err, busy, WR, RD, rdata} !== {8'b0, rdata_m}) begin
        n_fail++;
        $display("FAIL idle_ack: gnt=%b done=%b err=%b busy=%b WR=%b RD=%b rdata=%h, want 0s rdata=%h", gnt, done, err, busy, WR, RD, rdata, rdata_m);
      end
      @(posedge CLK); @(negedge CLK);
    end
  endtask
  task automatic test_random;
    for (int i = 0; i < 40; i++) begin
      if (i == 0 || $urandom_range(0, 2) != 0) begin
        req = 2'($urandom_range(1, 3));
        we = 2'($urandom);
        addr = 22'($urandom);
        wdata = 16'($urandom);
      end else if (req == 0) req = 2'b11;
      do_txn($urandom_range(0, TO + 2), 8'($urandom), $urandom_range(0, 4) == 0);
    end
    req = 0;
  endtask
  initial begin
    @(negedge CLK);
    test_reset;
    test_write;
    test_read;
    test_back_to_back;
    test_timeout;
    test_reset_mid;
    test_drop_and_spurious;
    test_random;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
